// File: rtl/wfg_interconnect.sv
// Wishbone-style slave-to-peripheral interconnect.
// Decodes the page index (upper address bits) of each master request onto one
// of NUM_PERIPH peripheral slots, forwards the latched register offset, write
// data and write enable, and returns the selected slot's read data. Misses and
// peripheral timeouts produce a one-cycle bus error. The address of the last
// erroring request is recorded, and errors are counted with saturation.
// Ports:
//   io_wbs_clk, io_wbs_rst_n       clock, async active-low reset
//   io_wbs_adr/datwr/we/stb/cyc    master request
//   io_wbs_datrd/ack/err           master response (registered)
//   periph_stb_o/adr_o/dat_o/we_o  per-slot strobe and latched request fields
//   periph_ack_i/dat_i             per-slot ack and read data (slot k at [k*BUSW +: BUSW])
//   err_addr_o, err_cnt_o          last error address, saturating error count
module wfg_interconnect #(
  parameter int BUSW       = 32,
  parameter int NUM_PERIPH = 4,
  parameter int PAGE_BITS  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       io_wbs_clk,
  input  logic                       io_wbs_rst_n,
  input  logic [BUSW-1:0]            io_wbs_adr,
  input  logic [BUSW-1:0]            io_wbs_datwr,
  input  logic                       io_wbs_we,
  input  logic                       io_wbs_stb,
  input  logic                       io_wbs_cyc,
  output logic [BUSW-1:0]            io_wbs_datrd,
  output logic                       io_wbs_ack,
  output logic                       io_wbs_err,
  output logic [NUM_PERIPH-1:0]      periph_stb_o,
  output logic [PAGE_BITS-1:0]       periph_adr_o,
  output logic [BUSW-1:0]            periph_dat_o,
  output logic                       periph_we_o,
  input  logic [NUM_PERIPH-1:0]      periph_ack_i,
  input  logic [NUM_PERIPH*BUSW-1:0] periph_dat_i,
  output logic [BUSW-1:0]            err_addr_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int PAGE_W = BUSW - PAGE_BITS;
  localparam int SLOT_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t                  state, state_nx;
  logic [PAGE_W-1:0]       page;
  logic                    req, hit;
  logic [SLOT_W-1:0]       slot_req, slot_q, slot_src;
  logic [BUSW-1:0]         adr_q;
  logic [TCNT_W-1:0]       tcnt, tcnt_nx;
  logic                    sel_ack;
  logic [BUSW-1:0]         sel_dat;
  logic [NUM_PERIPH-1:0]   stb_nx;
  logic [BUSW-1:0]         datrd_nx;
  logic                    ack_nx, err_nx;

  // Page 0 is the null page; page k+1 maps to slot k.
  assign page     = io_wbs_adr[BUSW-1:PAGE_BITS];
  assign req      = io_wbs_cyc & io_wbs_stb;
  assign hit      = (page != '0) && (page <= PAGE_W'(NUM_PERIPH));
  assign slot_req = SLOT_W'(page - PAGE_W'(1));

  // Only the latched slot's ack/data are visible; all other acks are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
      if (slot_q == SLOT_W'(k)) begin
        sel_ack = periph_ack_i[k];
        sel_dat = periph_dat_i[k*BUSW +: BUSW];
      end
    end
  end

  // State register
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) state <= IDLE;
    else               state <= state_nx;
  end

  // Next-state logic; an aborted cycle takes priority over ack, ack over timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = hit ? WAIT : ERR;
      WAIT: begin
        if (!io_wbs_cyc)                         state_nx = IDLE;
        else if (sel_ack)                        state_nx = RESP;
        else if (tcnt == TCNT_W'(TIMEOUT - 1))   state_nx = ERR;
      end
      RESP:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: outputs are registered, so their next values are derived
  // from the next state, giving ack/err/strobe aligned with RESP/ERR/WAIT.
  always_comb begin
    slot_src = (state == IDLE) ? slot_req : slot_q;
    stb_nx   = '0;
    for (int unsigned k = 0; k < NUM_PERIPH; k++)
      stb_nx[k] = (state_nx == WAIT) && (slot_src == SLOT_W'(k));
    ack_nx   = (state_nx == RESP);
    err_nx   = (state_nx == ERR);
    datrd_nx = (state_nx == RESP && !periph_we_o) ? sel_dat : '0;
    tcnt_nx  = (state == WAIT && state_nx == WAIT) ? tcnt + TCNT_W'(1) : '0;
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      io_wbs_ack   <= 1'b0;
      io_wbs_err   <= 1'b0;
      io_wbs_datrd <= '0;
      periph_stb_o <= '0;
      periph_adr_o <= '0;
      periph_dat_o <= '0;
      periph_we_o  <= 1'b0;
      err_addr_o   <= '0;
      err_cnt_o    <= '0;
      adr_q        <= '0;
      slot_q       <= '0;
      tcnt         <= '0;
    end else begin
      io_wbs_ack   <= ack_nx;
      io_wbs_err   <= err_nx;
      io_wbs_datrd <= datrd_nx;
      periph_stb_o <= stb_nx;
      tcnt         <= tcnt_nx;
      if (state == IDLE && req) begin
        adr_q        <= io_wbs_adr;
        slot_q       <= slot_req;
        periph_adr_o <= io_wbs_adr[PAGE_BITS-1:0];
        periph_dat_o <= io_wbs_datwr;
        periph_we_o  <= io_wbs_we;
      end
      // A miss enters ERR straight from IDLE, before adr_q has been loaded.
      if (state_nx == ERR) begin
        err_addr_o <= (state == IDLE) ? io_wbs_adr : adr_q;
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wfg_interconnect.sv
// Self-checking bench for wfg_interconnect: directed and randomized
// transactions checked cycle-by-cycle against a transaction-level model.
module tb_wfg_interconnect;

  localparam int BUSW = 32;
  localparam int NP   = 4;
  localparam int PB   = 4;
  localparam int TO   = 16;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BUSW-1:0]   adr, datwr, datrd;
  logic              we, stb, cyc, ack, err;
  logic [NP-1:0]     p_stb, p_ack;
  logic [PB-1:0]     p_adr;
  logic [BUSW-1:0]   p_dat_o, err_addr;
  logic              p_we;
  logic [NP*BUSW-1:0] p_dat_i;
  logic [7:0]        err_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference error bookkeeping
  logic [31:0] m_err_addr;
  int          m_err_cnt;

  always #5 clk = ~clk;

  wfg_interconnect #(.BUSW(BUSW), .NUM_PERIPH(NP), .PAGE_BITS(PB), .TIMEOUT(TO)) dut (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n),
    .io_wbs_adr(adr), .io_wbs_datwr(datwr), .io_wbs_we(we),
    .io_wbs_stb(stb), .io_wbs_cyc(cyc),
    .io_wbs_datrd(datrd), .io_wbs_ack(ack), .io_wbs_err(err),
    .periph_stb_o(p_stb), .periph_adr_o(p_adr), .periph_dat_o(p_dat_o), .periph_we_o(p_we),
    .periph_ack_i(p_ack), .periph_dat_i(p_dat_i),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stb"},  32'(p_stb), 0);
    check_eq({tag, "_ack"},  32'(ack), 0);
    check_eq({tag, "_err"},  32'(err), 0);
    check_eq({tag, "_dat"},  datrd, 0);
    check_eq({tag, "_padr"}, 32'(p_adr), 0);
    check_eq({tag, "_pdat"}, p_dat_o, 0);
    check_eq({tag, "_pwe"},  32'(p_we), 0);
    check_eq({tag, "_eadr"}, err_addr, 0);
    check_eq({tag, "_ecnt"}, 32'(err_cnt), 0);
  endtask

  // Peripheral side for WAIT index w: the selected slot acks only at w==d;
  // other slots get no ack (0), random acks (1) or constant acks (2).
  task automatic drive_slaves(input bit hit, input int slot, input int w, input int d,
                              input logic [31:0] rdat, input int noise);
    for (int k = 0; k < NP; k++) begin
      if (hit && k == slot) begin
        p_ack[k] = (w == d);
        p_dat_i[k*BUSW +: BUSW] = rdat;
      end else begin
        p_ack[k] = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        p_dat_i[k*BUSW +: BUSW] = $urandom;
      end
    end
  endtask

  // One transaction, entered and left on a negedge with the DUT idle.
  // d: WAIT cycle (0 = first) in which the slave acks; a: WAIT cycle in which
  // the master drops cyc. Outcome is derived from which event comes first.
  task automatic run_txn(input logic [31:0] a_adr, input logic a_we, input logic [31:0] wdat,
                         input logic [31:0] rdat, input int d, input int a, input int noise);
    int page, slot, endi, resp_c, last_c, kind; // kind: 0 ack, 1 err, 2 abort
    bit hit, in_wait;
    logic [NP-1:0] onehot;
    logic [31:0] exp_stb;
    page = int'(a_adr >> PB);
    hit  = (page >= 1) && (page <= NP);
    slot = page - 1;
    onehot = hit ? (NP'(1) << slot) : '0;
    if (!hit) begin
      kind = 1; endi = -1; resp_c = 1; last_c = 2;
    end else begin
      endi = d;
      if (TO - 1 < endi) endi = TO - 1;
      if (a < endi) endi = a;
      if (a == endi) begin
        kind = 2; resp_c = -1; last_c = endi + 2;
      end else begin
        kind = (d == endi) ? 0 : 1;
        resp_c = endi + 2; last_c = resp_c + 1;
      end
    end
    if (kind == 1) begin
      m_err_addr = a_adr;
      if (m_err_cnt < 255) m_err_cnt++;
    end

    adr = a_adr; we = a_we; datwr = wdat; cyc = 1'b1; stb = 1'b1;
    drive_slaves(hit, slot, -1, d, rdat, noise);
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= last_c; c++) begin
      in_wait = hit && (c <= endi + 1);
      exp_stb = in_wait ? 32'(onehot) : 32'd0;
      check_eq("stb", 32'(p_stb), exp_stb);
      check_eq("ack", 32'(ack), 32'(kind == 0 && c == resp_c));
      check_eq("err", 32'(err), 32'(kind == 1 && c == resp_c));
      check_eq("datrd", datrd, (kind == 0 && c == resp_c && !a_we) ? rdat : 32'd0);
      if (in_wait) begin
        check_eq("padr", 32'(p_adr), 32'(a_adr[PB-1:0]));
        check_eq("pdat", p_dat_o, wdat);
        check_eq("pwe",  32'(p_we), 32'(a_we));
      end
      if (c < last_c) begin
        stb = 1'b0;
        cyc = !(kind == 2 && (c - 1) >= a) && !(resp_c > 0 && c >= resp_c);
        drive_slaves(hit, slot, c - 1, d, rdat, noise);
        @(negedge clk);
      end
    end
    check_eq("err_addr", err_addr, m_err_addr);
    check_eq("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
  endtask

  initial begin
    logic [31:0] r_adr;
    int pg, r, dd, aa;
    rst_n = 1'b0; adr = '0; datwr = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    p_ack = '0; p_dat_i = '0;
    m_err_addr = '0; m_err_cnt = 0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // Read 0x24, slot 1 acks at once
    run_txn(32'h24, 1'b0, 32'h0, 32'hCAFE0001, 0, NEVER, 0);
    // Write to null page
    run_txn(32'h0C, 1'b1, 32'h1234, 32'h0, 0, NEVER, 0);
    // Slot 2 never acks -> timeout
    run_txn(32'h30, 1'b0, 32'h0, 32'hDEAD0002, NEVER, NEVER, 0);
    // Other slots ack constantly while slot 1 acks late
    run_txn(32'h20, 1'b0, 32'h0, 32'h5151A5A5, 3, NEVER, 2);
    // Abort in WAIT, then a normal request to slot 0
    run_txn(32'h20, 1'b0, 32'h0, 32'h11111111, NEVER, 1, 1);
    run_txn(32'h10, 1'b0, 32'h0, 32'hABCD0010, 2, NEVER, 0);
    // Ack coinciding with timeout wins; ack one cycle too late loses
    run_txn(32'h47, 1'b0, 32'h0, 32'h0BADF00D, TO - 1, NEVER, 1);
    run_txn(32'h47, 1'b0, 32'h0, 32'h0BADF00D, TO, NEVER, 1);
    // Page just beyond the last slot
    run_txn(32'h5F, 1'b0, 32'h0, 32'h0, 0, NEVER, 1);

    for (int i = 0; i < 200; i++) begin
      pg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NP + 1, 32'h0FFF_FFFF))
                                       : int'($urandom_range(0, NP + 2));
      r_adr = {pg[27:0], 4'($urandom_range(0, 15))};
      r = $urandom_range(0, 9);
      dd = (r <= 5) ? r : (r == 6) ? TO - 1 : (r == 7) ? TO : int'($urandom_range(0, 3));
      aa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : NEVER;
      run_txn(r_adr, 1'($urandom_range(0, 1)), $urandom, $urandom, dd, aa, 1);
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      pg = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(NP + 1, 32'h0FFF_FFFF));
      r_adr = {pg[27:0], 4'($urandom_range(0, 15))};
      run_txn(r_adr, 1'($urandom_range(0, 1)), $urandom, 32'h0, 0, NEVER, 1);
    end
    check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Async reset in the middle of WAIT
    adr = 32'h24; we = 1'b0; cyc = 1'b1; stb = 1'b1; p_ack = '0;
    @(posedge clk); @(negedge clk);
    check_eq("rst_wait_stb", 32'(p_stb), 32'h2);
    #2 rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1 check_all_zero("rst_mid");
    m_err_addr = '0; m_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    p_ack = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_no_ack", 32'(ack), 0);
      check_eq("rst_no_err", 32'(err), 0);
      check_eq("rst_no_stb", 32'(p_stb), 0);
    end
    p_ack = '0;
    run_txn(32'h24, 1'b0, 32'h0, 32'hCAFE0002, 1, NEVER, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so a stuck run still ends
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
